// File: rtl/eu_pkg.sv
// Types and helpers shared by the cluster event-unit blocks.
package eu_pkg;

   typedef enum logic [0:0] {
      StFree,
      StLocked
   } mutex_state_e;

   // Index width for an n-entry vector; never narrower than one bit.
   function automatic int unsigned eu_id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/eu_rr_pick.sv
// Combinational round-robin picker: first request at or above ptr_i, wrapping.
module eu_rr_pick
   import eu_pkg::*;
#(
   parameter int unsigned N   = 8,
   parameter int unsigned IdW = eu_id_width(N)
) (
   input  logic [N-1:0]   req_i,
   input  logic [IdW-1:0] ptr_i,
   output logic           valid_o,
   output logic [N-1:0]   grant_o,
   output logic [IdW-1:0] idx_o
);

   logic [2*N-1:0] dbl_req;
   logic [2*N-1:0] dbl_masked;

   // Upper copy is unmasked, so the lowest set bit of the masked doubled vector is the
   // first request at or above ptr_i, wrapping through the upper copy when needed.
   always_comb begin
      dbl_req    = {req_i, req_i};
      dbl_masked = dbl_req & ({(2*N){1'b1}} << ptr_i);
      valid_o    = |req_i;
      idx_o      = '0;
      for (int i = 2 * N - 1; i >= 0; i--) begin
         if (dbl_masked[i]) begin
            if (i >= int'(N)) begin
               idx_o = IdW'(i - int'(N));
            end else begin
               idx_o = IdW'(i);
            end
         end
      end
      grant_o = valid_o ? (N'(1) << idx_o) : '0;
   end

endmodule

// File: rtl/eu_mutex_rr_arbiter.sv
// Hardware mutex with round-robin handover, message passing and one-cycle grant events.
module eu_mutex_rr_arbiter
   import eu_pkg::*;
#(
   parameter int unsigned NB_CORES    = 8,
   parameter int unsigned MUTEX_MSG_W = 32,
   localparam int unsigned ID_W       = eu_id_width(NB_CORES)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NB_CORES-1:0]    lock_req_i,
   input  logic [NB_CORES-1:0]    unlock_req_i,
   input  logic [MUTEX_MSG_W-1:0] msg_wdata_i,
   output logic [MUTEX_MSG_W-1:0] msg_rdata_o,
   output logic [NB_CORES-1:0]    mutex_event_o,
   output logic                   owner_valid_o,
   output logic [ID_W-1:0]        owner_id_o,
   output logic [NB_CORES-1:0]    pending_o,
   output logic                   err_o,
   input  logic                   err_clr_i
);

   mutex_state_e           state_q, state_d;
   logic [ID_W-1:0]        owner_q, owner_d;
   logic [ID_W-1:0]        ptr_q, ptr_d;
   logic [NB_CORES-1:0]    pending_q, pending_d;
   logic [NB_CORES-1:0]    event_q, event_d;
   logic [MUTEX_MSG_W-1:0] msg_q, msg_d;
   logic                   err_q, err_d;

   logic [NB_CORES-1:0] owner_mask;
   logic [NB_CORES-1:0] arb_req;
   logic                owner_unlock;
   logic                owner_lock;
   logic                err_new;
   logic                pick_valid;
   logic [NB_CORES-1:0] pick_grant;
   logic [ID_W-1:0]     pick_idx;

   assign owner_mask   = (state_q == StLocked) ? (NB_CORES'(1) << owner_q) : '0;
   assign owner_unlock = |(unlock_req_i & owner_mask);
   assign owner_lock   = |(lock_req_i & owner_mask);
   // The owner never competes in its own handover; a re-lock with unlock waits as pending.
   assign arb_req      = pending_q | (lock_req_i & ~owner_mask);
   assign err_new      = (|(unlock_req_i & ~owner_mask)) | (owner_lock & ~owner_unlock);

   eu_rr_pick #(
      .N   (NB_CORES),
      .IdW (ID_W)
   ) u_pick (
      .req_i   (arb_req),
      .ptr_i   (ptr_q),
      .valid_o (pick_valid),
      .grant_o (pick_grant),
      .idx_o   (pick_idx)
   );

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      msg_d     = msg_q;
      event_d   = '0;
      pending_d = arb_req | (owner_unlock ? (lock_req_i & owner_mask) : '0);

      unique case (state_q)
         StFree: begin
            if (pick_valid) begin
               state_d   = StLocked;
               owner_d   = pick_idx;
               event_d   = pick_grant;
               pending_d = pending_d & ~pick_grant;
               ptr_d     = (pick_idx == ID_W'(NB_CORES - 1)) ? '0 : pick_idx + ID_W'(1);
            end
         end
         StLocked: begin
            if (owner_unlock) begin
               msg_d = msg_wdata_i;
               if (pick_valid) begin
                  owner_d   = pick_idx;
                  event_d   = pick_grant;
                  pending_d = pending_d & ~pick_grant;
                  ptr_d     = (pick_idx == ID_W'(NB_CORES - 1)) ? '0 : pick_idx + ID_W'(1);
               end else begin
                  state_d = StFree;
                  owner_d = '0;
               end
            end
         end
         default: state_d = StFree;
      endcase

      if (err_new) begin
         err_d = 1'b1;
      end else if (err_clr_i) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StFree;
         owner_q   <= '0;
         ptr_q     <= '0;
         pending_q <= '0;
         event_q   <= '0;
         msg_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         pending_q <= pending_d;
         event_q   <= event_d;
         msg_q     <= msg_d;
         err_q     <= err_d;
      end
   end

   assign msg_rdata_o   = msg_q;
   assign mutex_event_o = event_q;
   assign owner_valid_o = (state_q == StLocked);
   assign owner_id_o    = owner_q;
   assign pending_o     = pending_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_eu_mutex_rr_arbiter.sv
// Scoreboard bench for eu_mutex_rr_arbiter: driver feeds a queue-based model, monitor compares.
module tb_eu_mutex_rr_arbiter;

   localparam int N = 8;
   localparam int W = 32;

   logic         clk;
   logic         rst;
   logic [N-1:0] lock_req;
   logic [N-1:0] unlock_req;
   logic [W-1:0] msg_wdata;
   logic [W-1:0] msg_rdata;
   logic [N-1:0] mutex_event;
   logic         owner_valid;
   logic [2:0]   owner_id;
   logic [N-1:0] pending;
   logic         err;
   logic         err_clr;

   eu_mutex_rr_arbiter #(
      .NB_CORES    (N),
      .MUTEX_MSG_W (W)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .lock_req_i    (lock_req),
      .unlock_req_i  (unlock_req),
      .msg_wdata_i   (msg_wdata),
      .msg_rdata_o   (msg_rdata),
      .mutex_event_o (mutex_event),
      .owner_valid_o (owner_valid),
      .owner_id_o    (owner_id),
      .pending_o     (pending),
      .err_o         (err),
      .err_clr_i     (err_clr)
   );

   typedef struct {
      bit [N-1:0] ev;
      bit         ov;
      bit [2:0]   oid;
      bit [N-1:0] pend;
      bit [W-1:0] msg;
      bit         err;
   } exp_t;

   exp_t exp_q[$];

   // Reference model: owner as plain index (-1 when free), pending as a set of cores.
   int         m_owner;
   int         m_ptr;
   bit [N-1:0] m_pend;
   bit [W-1:0] m_msg;
   bit         m_err;

   int n_checks;
   int n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int first_from(input bit [N-1:0] cand, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (cand[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic step(input bit [N-1:0] lk, input bit [N-1:0] ul, input bit [W-1:0] msg,
                       input bit clr, input bit rs);
      exp_t       e;
      bit [N-1:0] ev;
      bit [N-1:0] cand;
      bit         unl;
      bit         errn;
      int         w;
      @(negedge clk);
      lock_req   = lk;
      unlock_req = ul;
      msg_wdata  = msg;
      err_clr    = clr;
      rst        = rs;
      ev = '0;
      if (rs) begin
         m_owner = -1;
         m_ptr   = 0;
         m_pend  = '0;
         m_msg   = '0;
         m_err   = 1'b0;
      end else begin
         unl  = (m_owner >= 0) && ul[m_owner];
         errn = 1'b0;
         cand = m_pend;
         for (int i = 0; i < N; i++) begin
            if (ul[i] && i != m_owner) errn = 1'b1;
            if (lk[i] && i == m_owner && !unl) errn = 1'b1;
            if (lk[i] && i != m_owner) cand[i] = 1'b1;
         end
         m_pend = cand;
         if (unl) begin
            m_msg = msg;
            if (lk[m_owner]) m_pend[m_owner] = 1'b1;
         end
         if (m_owner < 0 || unl) begin
            w = first_from(cand, m_ptr);
            if (w >= 0) begin
               m_pend[w] = 1'b0;
               m_owner   = w;
               ev[w]     = 1'b1;
               m_ptr     = (w + 1) % N;
            end else begin
               m_owner = -1;
            end
         end
         if (errn) m_err = 1'b1;
         else if (clr) m_err = 1'b0;
      end
      e.ev   = ev;
      e.ov   = (m_owner >= 0);
      e.oid  = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
      e.pend = m_pend;
      e.msg  = m_msg;
      e.err  = m_err;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step('0, '0, '0, 1'b0, 1'b0);
   endtask

   // Monitor: each registered output set is checked just after the edge it belongs to.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("mutex_event", 64'(mutex_event), 64'(e.ev));
            check("owner_valid", 64'(owner_valid), 64'(e.ov));
            check("owner_id", 64'(owner_id), 64'(e.oid));
            check("pending", 64'(pending), 64'(e.pend));
            check("msg_rdata", 64'(msg_rdata), 64'(e.msg));
            check("err", 64'(err), 64'(e.err));
            if (mutex_event !== '0 && !$onehot(mutex_event)) begin
               check("event_onehot", 64'(mutex_event), 64'(e.ev));
            end
         end
      end
   end

   initial begin
      bit [N-1:0] lk;
      bit [N-1:0] ul;
      int         guard;
      n_checks   = 0;
      n_fail     = 0;
      rst        = 1'b1;
      lock_req   = '0;
      unlock_req = '0;
      msg_wdata  = '0;
      err_clr    = 1'b0;
      m_owner    = -1;

      step('0, '0, '0, 1'b0, 1'b1);
      idle(2);

      // Single lock and release with message.
      step(8'h04, '0, '0, 1'b0, 1'b0);
      idle(1);
      step('0, 8'h04, 32'hDEADBEEF, 1'b0, 1'b0);
      idle(1);

      // Fairness: core 0 owns, cores 1/3/7 queue up, back-to-back handovers.
      step(8'h01, '0, '0, 1'b0, 1'b0);
      step(8'h8A, '0, '0, 1'b0, 1'b0);
      step('0, 8'h01, 32'h1, 1'b0, 1'b0);
      step('0, 8'h02, 32'h2, 1'b0, 1'b0);
      step('0, 8'h08, 32'h3, 1'b0, 1'b0);
      step('0, 8'h80, 32'h4, 1'b0, 1'b0);
      idle(1);

      // Wrap-around: pointer at 6 after core 5, pending 0 and 4.
      step(8'h20, '0, '0, 1'b0, 1'b0);
      step(8'h11, '0, '0, 1'b0, 1'b0);
      step('0, 8'h20, 32'h55, 1'b0, 1'b0);
      step('0, 8'h01, 32'h66, 1'b0, 1'b0);
      step('0, 8'h10, 32'h77, 1'b0, 1'b0);
      idle(1);

      // Simultaneous requests, then owner unlock+lock in one cycle.
      step('0, '0, '0, 1'b0, 1'b1);
      step(8'hFF, '0, '0, 1'b0, 1'b0);
      step(8'h01, 8'h01, 32'hA5A5, 1'b0, 1'b0);
      guard = 0;
      while (m_owner >= 0 && guard < 20) begin
         step('0, N'(1) << m_owner, $urandom, 1'b0, 1'b0);
         guard++;
      end
      idle(1);

      // Protocol errors and clearing.
      step(8'h02, '0, '0, 1'b0, 1'b0);
      step('0, 8'h08, 32'hBAD, 1'b0, 1'b0);
      step('0, 8'h02, 32'h600D, 1'b0, 1'b0);
      step('0, 8'h04, 32'hBAD2, 1'b0, 1'b0);
      step('0, '0, '0, 1'b1, 1'b0);
      step(8'h01, '0, '0, 1'b0, 1'b0);
      step(8'h01, '0, '0, 1'b0, 1'b0);
      step('0, 8'h40, '0, 1'b1, 1'b0);
      step('0, 8'h01, 32'h9, 1'b1, 1'b0);

      // Reset mid-operation.
      step(8'h04, '0, '0, 1'b0, 1'b0);
      step(8'h30, '0, '0, 1'b0, 1'b0);
      step('0, '0, '0, 1'b0, 1'b1);
      idle(3);

      // Randomized traffic.
      for (int c = 0; c < 2000; c++) begin
         lk = N'($urandom & $urandom & $urandom);
         ul = '0;
         if (m_owner >= 0 && ($urandom % 3) == 0) ul = N'(1) << m_owner;
         if (($urandom % 40) == 0) ul = ul | (N'(1) << ($urandom % N));
         step(lk, ul, $urandom, ($urandom % 16) == 0, ($urandom % 300) == 0);
      end
      idle(3);

      guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      #2;
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
